// File: rtl/dual_issue_scheduler_if.sv
// Fetch-buffer / execute-lane bundle for the dual-issue scheduler.
// The master drives the buffer view. The slave is the scheduler.
interface dual_issue_scheduler_if;
  logic        nothing_filled;
  logic [31:0] instruction0;
  logic [31:0] instruction1;
  logic        exec_stall;
  logic        redirect;
  logic        freeze1;
  logic        freeze2;
  logic        dependency_on_ins2;
  logic        issue0_valid;
  logic [31:0] issue0_instr;
  logic        issue1_valid;
  logic [31:0] issue1_instr;
  logic [15:0] stall_count;

  modport master (
    output nothing_filled, instruction0, instruction1, exec_stall, redirect,
    input  freeze1, freeze2, dependency_on_ins2,
    input  issue0_valid, issue0_instr, issue1_valid, issue1_instr, stall_count
  );

  modport slave (
    input  nothing_filled, instruction0, instruction1, exec_stall, redirect,
    output freeze1, freeze2, dependency_on_ins2,
    output issue0_valid, issue0_instr, issue1_valid, issue1_instr, stall_count
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: pairs the two oldest buffered instructions and holds
// back consumers of loads that are still in flight, using a per-register scoreboard.
module dual_issue_scheduler #(
  parameter int unsigned LOAD_LAT = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  dual_issue_scheduler_if.slave  bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [2:0] LOAD_SET  = 3'(LOAD_LAT - 1);

  function automatic logic writes_rd(input logic [6:0] op);
    return !(op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OP_OP || op == OP_STORE || op == OP_BRANCH;
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return op == OP_JAL || op == OP_JALR || op == OP_BRANCH;
  endfunction

  logic [2:0]  cnt [32];
  logic [31:0] busy;
  logic [31:0] load_hit;
  logic [6:0]  op0, op1;
  logic [4:0]  rd0, rd1, rs1_0, rs2_0, rs1_1, rs2_1;
  logic        src_ok0, src_ok1, raw, waw, iss0, iss1;

  assign op0   = bus.instruction0[6:0];
  assign rd0   = bus.instruction0[11:7];
  assign rs1_0 = bus.instruction0[19:15];
  assign rs2_0 = bus.instruction0[24:20];
  assign op1   = bus.instruction1[6:0];
  assign rd1   = bus.instruction1[11:7];
  assign rs1_1 = bus.instruction1[19:15];
  assign rs2_1 = bus.instruction1[24:20];

  always_comb begin
    busy = '0;
    for (int unsigned i = 1; i < 32; i++) busy[i] = (cnt[i] != '0);
  end

  always_comb begin
    src_ok0 = !(uses_rs1(op0) && busy[rs1_0]) && !(uses_rs2(op0) && busy[rs2_0]);
    src_ok1 = !(uses_rs1(op1) && busy[rs1_1]) && !(uses_rs2(op1) && busy[rs2_1]);
    raw     = writes_rd(op0) && (rd0 != '0) &&
              ((uses_rs1(op1) && rs1_1 == rd0) || (uses_rs2(op1) && rs2_1 == rd0));
    waw     = writes_rd(op0) && writes_rd(op1) && (rd0 != '0) && (rd1 == rd0);
    iss0    = rst_n && !bus.nothing_filled && !bus.exec_stall && !bus.redirect && src_ok0;
    iss1    = iss0 && !is_ctrl(op0) && !raw && !waw &&
              !(is_mem(op0) && is_mem(op1)) && src_ok1;
    bus.freeze1            = !iss0;
    bus.freeze2            = !iss0 && bus.exec_stall && rst_n;
    bus.dependency_on_ins2 = iss0 && !iss1;
  end

  // Slot 0 and slot 1 can never both be loads, so at most one register is marked per cycle.
  always_comb begin
    load_hit = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      load_hit[i] = (iss0 && op0 == OP_LOAD && rd0 == 5'(i)) ||
                    (iss1 && op1 == OP_LOAD && rd1 == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.issue0_valid <= 1'b0;
      bus.issue0_instr <= '0;
      bus.issue1_valid <= 1'b0;
      bus.issue1_instr <= '0;
      bus.stall_count  <= '0;
      cnt              <= '{default: '0};
    end else begin
      bus.issue0_valid <= iss0;
      bus.issue0_instr <= iss0 ? bus.instruction0 : '0;
      bus.issue1_valid <= iss1;
      bus.issue1_instr <= iss1 ? bus.instruction1 : '0;
      if (!iss0 && !bus.nothing_filled && bus.stall_count != '1)
        bus.stall_count <= bus.stall_count + 16'd1;
      for (int unsigned i = 0; i < 32; i++) begin
        if (load_hit[i])      cnt[i] <= LOAD_SET;
        else if (cnt[i] != '0) cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Randomized and directed bench for dual_issue_scheduler against a
// cycle-stamp reference model (register ready times instead of counters).
module tb_dual_issue_scheduler;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dual_issue_scheduler_if bus ();

  dual_issue_scheduler #(.LOAD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: a register written by a load decided in cycle c is ready from cycle c+LAT.
  int          ready [32];
  int          cyc = 0;
  int          m_stall = 0;
  bit          m_v0, m_v1, reg_known = 0;
  logic [31:0] m_i0, m_i1;

  function automatic bit wr(input logic [6:0] op);
    return !(op inside {7'b0100011, 7'b1100011});
  endfunction
  function automatic bit rs1u(input logic [6:0] op);
    return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic bit rs2u(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit mem(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011};
  endfunction
  function automatic bit ctrl(input logic [6:0] op);
    return op inside {7'b1101111, 7'b1100111, 7'b1100011};
  endfunction
  function automatic bit reg_busy(input int r);
    return r != 0 && cyc < ready[r];
  endfunction
  function automatic bit srcs_ready(input logic [31:0] ins);
    return !((rs1u(ins[6:0]) && reg_busy(int'(ins[19:15]))) ||
             (rs2u(ins[6:0]) && reg_busy(int'(ins[24:20]))));
  endfunction

  task automatic cycle(input bit r, input bit nf, input bit es, input bit rdir,
                       input logic [31:0] a, input logic [31:0] b);
    bit e0, e1, pair_ok, raw, waw;
    logic [4:0] rd0, rd1;
    @(negedge clk);
    if (reg_known) begin
      check("issue0_valid", 32'(bus.issue0_valid), 32'(m_v0));
      check("issue0_instr", bus.issue0_instr, m_i0);
      check("issue1_valid", 32'(bus.issue1_valid), 32'(m_v1));
      check("issue1_instr", bus.issue1_instr, m_i1);
      check("stall_count", 32'(bus.stall_count), 32'(m_stall));
    end
    rst_n              = r;
    bus.nothing_filled = nf;
    bus.exec_stall     = es;
    bus.redirect       = rdir;
    bus.instruction0   = a;
    bus.instruction1   = b;
    #1;
    rd0     = a[11:7];
    rd1     = b[11:7];
    e0      = r && !nf && !es && !rdir && srcs_ready(a);
    raw     = wr(a[6:0]) && rd0 != 0 &&
              ((rs1u(b[6:0]) && b[19:15] == rd0) || (rs2u(b[6:0]) && b[24:20] == rd0));
    waw     = wr(a[6:0]) && wr(b[6:0]) && rd0 != 0 && rd0 == rd1;
    pair_ok = !ctrl(a[6:0]) && !raw && !waw && !(mem(a[6:0]) && mem(b[6:0])) && srcs_ready(b);
    e1      = e0 && pair_ok;
    check("freeze1", 32'(bus.freeze1), 32'(!e0));
    check("freeze2", 32'(bus.freeze2), 32'(!e0 && es && r));
    check("dependency_on_ins2", 32'(bus.dependency_on_ins2), 32'(e0 && !e1));
    if (!r) begin
      foreach (ready[i]) ready[i] = 0;
      m_stall = 0;
      m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0;
    end else begin
      m_v0 = e0; m_i0 = e0 ? a : '0;
      m_v1 = e1; m_i1 = e1 ? b : '0;
      if (!e0 && !nf && m_stall < 65535) m_stall++;
      if (e0 && a[6:0] == 7'b0000011 && rd0 != 0) ready[rd0] = cyc + int'(LAT);
      if (e1 && b[6:0] == 7'b0000011 && rd1 != 0) ready[rd1] = cyc + int'(LAT);
    end
    cyc++;
    reg_known = 1;
  endtask

  logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                           7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011, 7'b0010011,
                           7'b0110011};

  function automatic logic [31:0] rand_ins();
    logic [4:0] rd, s1, s2;
    rd = 5'($urandom_range(0, 5));
    s1 = 5'($urandom_range(0, 5));
    s2 = 5'($urandom_range(0, 5));
    return {7'($urandom), s2, s1, 3'($urandom), rd, ops[$urandom_range(0, 10)]};
  endfunction

  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] ADDI3 = 32'h00300193;
  localparam logic [31:0] ADD3  = 32'h001081B3;
  localparam logic [31:0] LW5   = 32'h00002283;
  localparam logic [31:0] USE5  = 32'h00028333;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] JAL0  = 32'h0000006F;
  localparam logic [31:0] SW7   = 32'h00702223;

  int s0;

  initial begin
    foreach (ready[i]) ready[i] = 0;
    // Reset held for two cycles with valid instructions present.
    cycle(0, 0, 0, 0, ADDI1, ADDI2);
    check("rst_freeze1", 32'(bus.freeze1), 32'd1);
    cycle(0, 0, 0, 0, ADDI1, ADDI2);
    // Independent pair.
    cycle(1, 0, 0, 0, ADDI1, ADDI2);
    check("pair_dep", 32'(bus.dependency_on_ins2), 32'd0);
    check("pair_f1", 32'(bus.freeze1), 32'd0);
    // Intra-pair RAW, then a normal pair.
    cycle(1, 0, 0, 0, ADDI1, ADD3);
    check("raw_pair_ok", 32'(bus.issue1_valid & bus.issue0_valid), 32'd1);
    check("raw_dep", 32'(bus.dependency_on_ins2), 32'd1);
    cycle(1, 0, 0, 0, ADDI2, ADDI3);
    check("raw_lane1", 32'(bus.issue1_valid), 32'd0);
    // Load-use: two held cycles, then the consumer issues.
    s0 = 32'(bus.stall_count);
    cycle(1, 0, 0, 0, LW5, USE5);
    check("ld_dep", 32'(bus.dependency_on_ins2), 32'd1);
    cycle(1, 0, 0, 0, USE5, NOP);
    check("ldu_f1_a", 32'(bus.freeze1), 32'd1);
    cycle(1, 0, 0, 0, USE5, NOP);
    check("ldu_f1_b", 32'(bus.freeze1), 32'd1);
    cycle(1, 0, 0, 0, USE5, NOP);
    check("ldu_issue", 32'(bus.freeze1), 32'd0);
    check("ldu_stalls", 32'(bus.stall_count) - 32'(s0), 32'd2);
    // Control op in slot 0, memory pair, exec_stall, redirect + exec_stall, empty buffer.
    cycle(1, 0, 0, 0, JAL0, ADDI1);
    check("jal_dep", 32'(bus.dependency_on_ins2), 32'd1);
    cycle(1, 0, 0, 0, LW5, SW7);
    check("mem_dep", 32'(bus.dependency_on_ins2), 32'd1);
    cycle(1, 0, 1, 0, ADDI1, ADDI2);
    check("es_f2", 32'(bus.freeze2 & bus.freeze1), 32'd1);
    cycle(1, 0, 1, 1, ADDI1, ADDI2);
    check("rd_es_f2", 32'(bus.freeze2), 32'd1);
    cycle(1, 1, 0, 0, ADDI1, ADDI2);
    check("nf_f1", 32'(bus.freeze1), 32'd1);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 99) >= 2, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, rand_ins(), rand_ins());
    end
    // Saturation, then reset clears the count.
    for (int i = 0; i < 70000; i++) cycle(1, 0, 1, 0, ADDI1, ADDI2);
    cycle(1, 0, 1, 0, ADDI1, ADDI2);
    check("sat_ffff", 32'(bus.stall_count), 32'h0000FFFF);
    cycle(0, 0, 0, 0, ADDI1, ADDI2);
    cycle(1, 1, 0, 0, ADDI1, ADDI2);
    check("sat_rst", 32'(bus.stall_count), 32'd0);
    cycle(1, 1, 0, 0, ADDI1, ADDI2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
